mdu_seq: RTL

//  Iterative multiply/divide sequencer that owns the HI/LO register pair for MULTU/DIVU.

---
 rtl/mdu_seq_pkg.sv | 31 +++
 rtl/mdu_seq_if.sv | 20 ++
 rtl/mdu_seq_step.sv | 33 +++
 rtl/mdu_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared types and sizing for the iterative multiply/divide sequencer.
package mdu_seq_pkg;

  localparam int unsigned WIDE  = 32;
  localparam int unsigned CNT_W = $clog2(WIDE);

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_DIVU  = 2'b01,
    MDU_MULT  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIN  = 2'b11
  } state_e;

  typedef struct packed {
    logic [WIDE-1:0] hi;
    logic [WIDE-1:0] lo;
  } mdu_res_t;

  // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
  function automatic logic [WIDE-1:0] mag(input logic [WIDE-1:0] x);
    return x[WIDE-1] ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Core <-> multiply/divide sequencer handshake and HI/LO read bus.
interface mdu_seq_if;
  import mdu_seq_pkg::*;

  logic            start;
  mdu_op_e         op;
  logic [WIDE-1:0] a;
  logic [WIDE-1:0] b;
  logic            rd_req;
  logic            busy;
  logic            done;
  logic            stall;
  logic [WIDE-1:0] hi;
  logic [WIDE-1:0] lo;

  modport master (output start, op, a, b, rd_req,
                  input  busy, done, stall, hi, lo);
  modport slave  (input  start, op, a, b, rd_req,
                  output busy, done, stall, hi, lo);
endinterface

// File: rtl/mdu_seq_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_step
  import mdu_seq_pkg::*;
(
  input  logic            mode_i,   // 1: divide, 0: multiply
  input  logic [WIDE:0]   acc_i,
  input  logic [WIDE-1:0] sr_i,
  input  logic [WIDE-1:0] opnd_i,
  output logic [WIDE:0]   acc_c,
  output logic [WIDE-1:0] sr_c
);

  logic [WIDE:0] sum_c;
  logic [WIDE:0] shl_c;

  always_comb begin
    sum_c = acc_i + (sr_i[0] ? {1'b0, opnd_i} : '0);
    shl_c = {acc_i[WIDE-1:0], sr_i[WIDE-1]};
    acc_c = {1'b0, sum_c[WIDE:1]};
    sr_c  = {sum_c[0], sr_i[WIDE-1:1]};
    if (mode_i) begin
      // Quotient bit shifts into the dividend register as the dividend shifts out.
      if (shl_c >= {1'b0, opnd_i}) begin
        acc_c = shl_c - {1'b0, opnd_i};
        sr_c  = {sr_i[WIDE-2:0], 1'b1};
      end else begin
        acc_c = shl_c;
        sr_c  = {sr_i[WIDE-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULTU/DIVU sequencer owning HI/LO; signed MULT/DIV when MDU_SIGNED_EN is defined.
module mdu_seq
  import mdu_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mdu_seq_if.slave  bus
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDE:0]   acc_q, acc_d;
  logic [WIDE-1:0] sr_q, sr_d;
  logic [WIDE-1:0] opnd_q, opnd_d;
  logic [WIDE-1:0] hi_q, hi_d;
  logic [WIDE-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [WIDE:0]   acc_c;
  logic [WIDE-1:0] sr_c;
  mdu_res_t        res_c;

`ifdef MDU_SIGNED_EN
  logic            mneg_q, mneg_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDE-1:0] araw_q, araw_d;
`endif

  mdu_step u_step (
    .mode_i (state_q == DIV),
    .acc_i  (acc_q),
    .sr_i   (sr_q),
    .opnd_i (opnd_q),
    .acc_c  (acc_c),
    .sr_c   (sr_c)
  );

  // Final HI/LO value presented on the FIN edge.
  always_comb begin
    res_c = '{hi: acc_q[WIDE-1:0], lo: sr_q};
`ifdef MDU_SIGNED_EN
    if (mneg_q) res_c = mdu_res_t'(-{acc_q[WIDE-1:0], sr_q});
    if (qneg_q) res_c.lo = -sr_q;
    if (rneg_q) res_c.hi = -acc_q[WIDE-1:0];
    if (dz_q)   res_c = '{hi: araw_q, lo: '1};
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = (state_q == MUL) || (state_q == DIV);
    done_d  = 1'b0;
`ifdef MDU_SIGNED_EN
    mneg_d  = mneg_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    araw_d  = araw_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          cnt_d = '0;
`ifdef MDU_SIGNED_EN
          mneg_d = 1'b0;
          qneg_d = 1'b0;
          rneg_d = 1'b0;
          dz_d   = 1'b0;
          araw_d = bus.a;
`endif
          case (bus.op)
            MDU_MULTU: begin
              state_d = MUL;
              sr_d    = bus.a;
              opnd_d  = bus.b;
            end
            MDU_DIVU: begin
              state_d = DIV;
              sr_d    = bus.a;
              opnd_d  = bus.b;
            end
`ifdef MDU_SIGNED_EN
            MDU_MULT: begin
              state_d = MUL;
              sr_d    = mag(bus.a);
              opnd_d  = mag(bus.b);
              mneg_d  = bus.a[WIDE-1] ^ bus.b[WIDE-1];
            end
            MDU_DIV: begin
              state_d = DIV;
              sr_d    = mag(bus.a);
              opnd_d  = mag(bus.b);
              qneg_d  = bus.a[WIDE-1] ^ bus.b[WIDE-1];
              rneg_d  = bus.a[WIDE-1];
              dz_d    = (bus.b == '0);
            end
`endif
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        acc_d = acc_c;
        sr_d  = sr_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDE-1)) begin
          state_d = FIN;
          cnt_d   = '0;
        end
      end
      FIN: begin
        hi_d    = res_c.hi;
        lo_d    = res_c.lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sr_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_SIGNED_EN
      mneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      araw_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_SIGNED_EN
      mneg_q  <= mneg_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      araw_q  <= araw_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q & (bus.rd_req | bus.start);

endmodule
